// File: rtl/key_debouncer_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
// The channel FSM state type is exported so the per-key state can be observed from the top level.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } key_state_t;

  localparam int KEY_STATE_W = $bits(key_state_t);

  // 10 ms debounce and 1 s long-press at a 50 MHz clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_HOLD_CYCLES     = 50000000;

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: two-flop synchronizer, debounce FSM with its debounce counter,
// and a saturating hold counter that produces a single long-press pulse per press.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  output logic       level,
  output logic       press,
  output logic       release_pulse,
  output logic       long_press,
  output key_state_t state
);

  localparam int DC_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_SAT  = HC_W'(HOLD_CYCLES);

  logic            sync_meta;
  logic            sync_s;
  key_state_t      state_nxt;
  logic [DC_W-1:0] dc;
  logic [DC_W-1:0] dc_nxt;
  logic [HC_W-1:0] hc;
  logic [HC_W-1:0] hc_nxt;
  logic            hold_run;
  logic            level_nxt;
  logic            press_nxt;
  logic            release_nxt;
  logic            long_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= ~key_n;
      sync_s    <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= RELEASED;
      dc            <= '0;
      hc            <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_nxt;
      dc            <= dc_nxt;
      hc            <= hc_nxt;
      level         <= level_nxt;
      press         <= press_nxt;
      release_pulse <= release_nxt;
      long_press    <= long_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dc_nxt      = dc;
    hc_nxt      = hc;
    hold_run    = 1'b0;
    level_nxt   = level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;

    case (state)
      RELEASED: begin
        if (sync_s) begin
          state_nxt = PRESS_PENDING;
          dc_nxt    = '0;
        end
      end

      PRESS_PENDING: begin
        if (!sync_s) begin
          state_nxt = RELEASED;
        end else if (dc == DC_LAST) begin
          state_nxt = PRESSED;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          hc_nxt    = '0;
        end else begin
          dc_nxt = dc + 1'b1;
        end
      end

      PRESSED: begin
        hold_run = 1'b1;
        if (!sync_s) begin
          state_nxt = RELEASE_PENDING;
          dc_nxt    = '0;
        end
      end

      RELEASE_PENDING: begin
        // The accepting release edge does not count as hold time, so a long-press
        // pulse can never coincide with the release pulse.
        if (sync_s) begin
          state_nxt = PRESSED;
          hold_run  = 1'b1;
        end else if (dc == DC_LAST) begin
          state_nxt   = RELEASED;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          dc_nxt   = dc + 1'b1;
          hold_run = 1'b1;
        end
      end

      default: begin
        state_nxt = RELEASED;
      end
    endcase

    // hc parks at HOLD_CYCLES after the pulse so the pulse cannot repeat.
    if (hold_run && (hc != HC_SAT)) begin
      hc_nxt   = hc + 1'b1;
      long_nxt = (hc == HC_LAST);
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Multi-key synchronizer/debouncer: NUM_KEYS independent channels producing a clean level
// plus registered press, release and long-press pulses. The release pulse is named
// release_pulse because release is a reserved word.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_KEYS-1:0]             key_n,
  output logic [NUM_KEYS-1:0]             level,
  output logic [NUM_KEYS-1:0]             press,
  output logic [NUM_KEYS-1:0]             release_pulse,
  output logic [NUM_KEYS-1:0]             long_press,
  output logic [NUM_KEYS*KEY_STATE_W-1:0] state_dbg
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_state_t ch_state;

    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .key_n        (key_n[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .state        (ch_state)
    );

    // Channel i occupies state_dbg[i*KEY_STATE_W +: KEY_STATE_W].
    assign state_dbg[i*KEY_STATE_W +: KEY_STATE_W] = ch_state;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer with DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, NUM_KEYS=4.
// A run-length reference model predicts every output cycle; directed tables and sequences pin the corner cases.
module tb_key_debouncer;

  localparam int NK = 4;
  localparam int DC = 4;
  localparam int HC = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] level;
  logic [NK-1:0] press;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] long_press;
  logic [NK*2-1:0] state_dbg;

  always #5 clk = ~clk;

  key_debouncer #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DC),
    .HOLD_CYCLES    (HC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .state_dbg    (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_press, cnt_rel, cnt_long;

  // ---------------- reference model ----------------
  // A change is accepted once the synchronized key has disagreed with the accepted level
  // for DC+1 consecutive edges; hold time counts edges spent pressed after acceptance.
  logic [NK-1:0]   hist[$];
  logic [NK-1:0]   m_level;
  int              m_run[NK];
  int              m_held[NK];
  logic [4*NK-1:0] exp_q[$];

  task automatic model_reset();
    hist = {};
    hist.push_back('0);
    hist.push_back('0);
    m_level = '0;
    for (int i = 0; i < NK; i++) begin
      m_run[i]  = 0;
      m_held[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [NK-1:0] kn);
    logic [NK-1:0] s, p, r, lp;
    logic was_pressed, flip;
    s = hist.pop_front();
    hist.push_back(~kn);
    p = '0; r = '0; lp = '0;
    for (int i = 0; i < NK; i++) begin
      was_pressed = m_level[i];
      flip = 1'b0;
      if (s[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DC + 1) flip = 1'b1;
      end else begin
        m_run[i] = 0;
      end
      if (flip) begin
        m_run[i]   = 0;
        m_level[i] = s[i];
        p[i]       = s[i];
        r[i]       = ~s[i];
        m_held[i]  = 0;
      end else if (was_pressed) begin
        m_held[i]++;
        if (m_held[i] == HC) lp[i] = 1'b1;
      end
    end
    exp_q.push_back({m_level, p, r, lp});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [4*NK-1:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL model_queue: got empty queue expected one entry");
    end else begin
      exp = exp_q.pop_front();
      if ({level, press, release_pulse, long_press} !== exp) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t: got lvl/prs/rel/long %b/%b/%b/%b expected %b/%b/%b/%b",
                 $time, level, press, release_pulse, long_press,
                 exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
      end
    end
    cnt_press += $countones(press);
    cnt_rel   += $countones(release_pulse);
    cnt_long  += $countones(long_press);
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
  task automatic step(input logic [NK-1:0] kn);
    key_n = kn;
    @(posedge clk);
    if (!reset) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      model_edge(kn);
    end
    #1;
    check_outputs();
  endtask

  task automatic clear_counts();
    cnt_press = 0;
    cnt_rel   = 0;
    cnt_long  = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string         name;
    logic [NK-1:0] kn;
    int            cycles;
    logic [NK-1:0] exp_level;
    int            exp_press;
    int            exp_rel;
    int            exp_long;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NK-1:0] kn;
    int rate;

    vecs[0]  = '{"idle",          4'b1111, 10, 4'b0000, 0, 0, 0};
    vecs[1]  = '{"press_k0",      4'b1110, 10, 4'b0001, 1, 0, 0};
    vecs[2]  = '{"release_k0",    4'b1111, 10, 4'b0000, 0, 1, 0};
    vecs[3]  = '{"hold_k2",       4'b1011, 40, 4'b0100, 1, 0, 1};
    vecs[4]  = '{"release_k2",    4'b1111, 10, 4'b0000, 0, 1, 0};
    vecs[5]  = '{"press_all",     4'b0000, 10, 4'b1111, 4, 0, 0};
    vecs[6]  = '{"release_all",   4'b1111, 10, 4'b0000, 0, 4, 0};
    vecs[7]  = '{"short_k2",      4'b1011, 15, 4'b0100, 1, 0, 0};
    vecs[8]  = '{"short_rel_k2",  4'b1111, 10, 4'b0000, 0, 1, 0};
    vecs[9]  = '{"hold_k3",       4'b0111, 20, 4'b1000, 1, 0, 0};
    vecs[10] = '{"long_in_relpend", 4'b1111, 10, 4'b0000, 0, 1, 1};

    model_reset();
    clear_counts();

    // Reset held with all keys pressed: everything stays zero.
    reset = 1'b0;
    key_n = 4'b0000;
    repeat (10) step(4'b0000);
    check("reset_outputs", {level, press, release_pulse, long_press}, 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(4'b0000);
      check($sformatf("post_reset_level0_e%0d", k), level[0], (k == 7));
    end
    check("post_reset_press_all", press, 4'b1111);
    repeat (10) step(4'b1111);

    // Table phases, applied back to back from the released state.
    foreach (vecs[v]) begin
      clear_counts();
      repeat (vecs[v].cycles) step(vecs[v].kn);
      check({vecs[v].name, "_level"}, level, vecs[v].exp_level);
      check({vecs[v].name, "_press"}, cnt_press, vecs[v].exp_press);
      check({vecs[v].name, "_release"}, cnt_rel, vecs[v].exp_rel);
      check({vecs[v].name, "_long"}, cnt_long, vecs[v].exp_long);
    end

    // Bounce on key 1: toggles every 2 cycles, then settles pressed.
    clear_counts();
    for (int c = 0; c < 20; c++) begin
      kn = 4'b1111;
      kn[1] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step(kn);
    end
    check("bounce_no_press", cnt_press, 0);
    check("bounce_no_release", cnt_rel, 0);
    for (int k = 1; k <= 7; k++) begin
      step(4'b1101);
      check($sformatf("bounce_level1_e%0d", k), level[1], (k == 7));
      check($sformatf("bounce_press1_e%0d", k), press[1], (k == 7));
    end
    step(4'b1101);
    check("bounce_press_one_cycle", press[1], 1'b0);
    repeat (10) step(4'b1111);

    // Exact long-press timing on key 2.
    for (int k = 1; k <= 30; k++) begin
      step(4'b1011);
      check($sformatf("long_press2_e%0d", k), press[2], (k == 7));
      check($sformatf("long_long2_e%0d", k), long_press[2], (k == 23));
    end
    repeat (10) step(4'b1111);

    // Simultaneous press on all keys.
    for (int k = 1; k <= 7; k++) begin
      step(4'b0000);
      check($sformatf("simul_press_e%0d", k), press, (k == 7) ? 4'b1111 : 4'b0000);
    end
    repeat (3) step(4'b0000);

    // Asynchronous reset while pressed: level clears at once, no release pulse.
    check("pre_reset_level3", level[3], 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset_level", level, 4'b0000);
    check("async_reset_no_release", release_pulse, 4'b0000);
    model_reset();
    clear_counts();
    repeat (3) step(4'b0000);
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(4'b0000);
      check($sformatf("redebounce_level3_e%0d", k), level[3], (k == 7));
    end
    check("reset_mid_press_no_release", cnt_rel, 0);
    repeat (10) step(4'b1111);

    // Randomized segments with varying toggle rates and occasional resets.
    kn = 4'b1111;
    for (int seg = 0; seg < 15; seg++) begin
      rate = $urandom_range(3, 40);
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < NK; i++)
          if ($urandom_range(0, rate - 1) == 0) kn[i] = ~kn[i];
        if ($urandom_range(0, 399) == 0) reset = 1'b0;
        step(kn);
        reset = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
